dpmem_responder: RTL
====================

DPMEM_RESPONDER -- requirements
Module: dpmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024; number of 32-bit words in the array, power of two, minimum 4.
REQ-002 The block SHALL have parameter LATENCY, default 2; cycles from request acceptance to resp, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-005 The block SHALL have port read_a, input, 1 bit; instruction-port read request, held until resp_a.
REQ-006 The block SHALL have port address_a, input, 32 bits; instruction byte address.
REQ-007 The block SHALL have port resp_a, output, 1 bit; one-cycle response pulse.
REQ-008 The block SHALL have port rdata_a, output, 32 bits; read data, valid with resp_a.
REQ-009 The block SHALL have port read_b, input, 1 bit; data-port read request.
REQ-010 The block SHALL have port write, input, 1 bit; data-port write request.
REQ-011 The block SHALL have port wmask, input, 4 bits; byte enables, bit i covers wdata[8i+7:8i].
REQ-012 The block SHALL have port address_b, input, 32 bits; data byte address.
REQ-013 The block SHALL have port wdata, input, 32 bits; write data.
REQ-014 The block SHALL have port resp_b, output, 1 bit; one-cycle response pulse for read or write.
REQ-015 The block SHALL have port rdata_b, output, 32 bits; read data, valid with resp_b.
REQ-016 The block SHALL have port proto_err, output, 1 bit; sticky protocol-violation flag.

Function
REQ-017 Each port SHALL run an independent FSM: IDLE -> WAIT -> RESP -> IDLE.
REQ-018 In IDLE, a request SHALL be accepted on the edge where it is high; at acceptance the address, wmask, wdata and direction SHALL be latched, and later input changes SHALL be ignored.
REQ-019 WAIT SHALL last LATENCY-1 cycles, counted by a down-counter; for LATENCY=1 the FSM SHALL go directly to RESP.
REQ-020 For a request accepted at edge t, resp SHALL be high for exactly the cycle following edge t+LATENCY-1, so that resp is observed at edge t+LATENCY.
REQ-021 The operation SHALL execute on the edge entering RESP: a write SHALL commit only the bytes with wmask set, and a read SHALL capture the array into rdata_x.
REQ-022 rdata_x SHALL hold its value until the next read response on that port; a write response SHALL leave rdata_b unchanged.
REQ-023 After RESP the FSM SHALL always spend one cycle in IDLE, so the earliest back-to-back request is accepted one cycle after resp.
REQ-024 Word index SHALL be address[log2(DEPTH_WORDS)+1:2]; address bits [1:0] and the upper bits SHALL be ignored, so out-of-range addresses wrap.
REQ-025 A port-A read and a port-B write to the same word executing on the same edge SHALL return the old data on rdata_a.
REQ-026 read_b and write both high in IDLE SHALL NOT be accepted; port B SHALL stay in IDLE.
REQ-027 A request dropped while in WAIT SHALL abort that port: return to IDLE, no resp, no write commit.

Reset
REQ-028 While rst_n is low, all FSMs SHALL be in IDLE, counters SHALL be 0, and resp_a, resp_b, rdata_a, rdata_b and proto_err SHALL all be 0.
REQ-029 Array contents SHALL NOT be reset, so preloaded contents are kept.
REQ-030 Reset asserted mid-operation SHALL discard the pending operation, and no write SHALL commit.
REQ-031 The first acceptance after reset SHALL be at the first edge with rst_n high.

Configuration
REQ-032 With DPMEM_PROTO_CHECK_EN defined, proto_err SHALL set on a REQ-026 or REQ-027 event and stay set until reset.
REQ-033 Without DPMEM_PROTO_CHECK_EN, proto_err SHALL be tied to 0 and the check logic SHALL be absent; REQ-026 and REQ-027 SHALL still apply.

Verification
REQ-034 A bench SHALL run LATENCY=2, word 0x10=0xDEADBEEF, read_a with address_a=0x40 held -> resp_a one cycle, 2 edges after acceptance, rdata_a=0xDEADBEEF.
REQ-035 A bench SHALL run write to 0x80 with wdata=0x11223344, wmask=0b0101 over old 0xAAAAAAAA, then read_b 0x80 -> rdata_b=0xAA22AA44, and rdata_b SHALL be unchanged at the write resp.
REQ-036 A bench SHALL run port A read and port B write of 0x5 to 0x20 accepted on the same edge -> rdata_a=old value, and a later read SHALL return 0x5.
REQ-037 A bench SHALL assert read_b and write together with the macro defined -> no resp_b, proto_err=1 and sticky; without the macro, proto_err=0.
REQ-038 A bench SHALL drop write during WAIT with LATENCY=4 -> no resp_b and memory unchanged; with rst_n pulsed low mid-WAIT -> outputs 0 and no commit.
REQ-039 A bench SHALL run DEPTH_WORDS=1024 and read_a address 0x1000 -> returns word 0 (wrap-around).

Source files
------------

// File: rtl/dpmem_responder.sv
// Dual-port word memory: port A reads, port B reads or writes with byte enables; each response comes LATENCY cycles after acceptance.
// Optional sticky protocol checker enabled by defining DPMEM_PROTO_CHECK_EN; the default build ties proto_err to 0.
module dpmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        proto_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  // ---------------- port A ----------------
  state_e        a_state_q;
  logic [3:0]    a_cnt_q;
  logic [AW-1:0] a_idx_q;
  logic          resp_a_q;
  logic [31:0]   rdata_a_q;
  logic          a_accept, a_abort, a_exec;
  logic [AW-1:0] a_exec_idx;

  assign a_accept   = (a_state_q == S_IDLE) && read_a;
  assign a_abort    = (a_state_q == S_WAIT) && !read_a;
  assign a_exec     = (LATENCY == 1) ? a_accept
                                     : ((a_state_q == S_WAIT) && read_a && (a_cnt_q == '0));
  assign a_exec_idx = (a_state_q == S_IDLE) ? address_a[AW+1:2] : a_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_q <= S_IDLE;
      a_cnt_q   <= '0;
      a_idx_q   <= '0;
      resp_a_q  <= 1'b0;
      rdata_a_q <= '0;
    end else begin
      resp_a_q <= 1'b0;
      if (a_exec) begin
        resp_a_q  <= 1'b1;
        rdata_a_q <= mem_q[a_exec_idx];
      end
      case (a_state_q)
        S_IDLE: begin
          if (a_accept) begin
            a_idx_q   <= address_a[AW+1:2];
            a_cnt_q   <= WAIT_INIT;
            a_state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (a_abort) begin
            a_state_q <= S_IDLE;
            a_cnt_q   <= '0;
          end else if (a_cnt_q == '0) begin
            a_state_q <= S_RESP;
          end else begin
            a_cnt_q <= a_cnt_q - 4'd1;
          end
        end
        S_RESP:  a_state_q <= S_IDLE;
        default: a_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- port B ----------------
  state_e        b_state_q;
  logic [3:0]    b_cnt_q;
  logic [AW-1:0] b_idx_q;
  logic          b_wr_q;
  logic [3:0]    b_mask_q;
  logic [31:0]   b_wdata_q;
  logic          resp_b_q;
  logic [31:0]   rdata_b_q;
  logic          b_accept, b_held, b_abort, b_exec, b_exec_wr;
  logic [AW-1:0] b_exec_idx;
  logic [3:0]    b_exec_mask;
  logic [31:0]   b_exec_wdata;

  // Simultaneous read_b and write is ambiguous, so neither is taken.
  assign b_accept     = (b_state_q == S_IDLE) && (read_b ^ write);
  assign b_held       = b_wr_q ? write : read_b;
  assign b_abort      = (b_state_q == S_WAIT) && !b_held;
  assign b_exec       = (LATENCY == 1) ? b_accept
                                       : ((b_state_q == S_WAIT) && b_held && (b_cnt_q == '0));
  assign b_exec_wr    = (b_state_q == S_IDLE) ? write             : b_wr_q;
  assign b_exec_idx   = (b_state_q == S_IDLE) ? address_b[AW+1:2] : b_idx_q;
  assign b_exec_mask  = (b_state_q == S_IDLE) ? wmask             : b_mask_q;
  assign b_exec_wdata = (b_state_q == S_IDLE) ? wdata             : b_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_state_q <= S_IDLE;
      b_cnt_q   <= '0;
      b_idx_q   <= '0;
      b_wr_q    <= 1'b0;
      b_mask_q  <= '0;
      b_wdata_q <= '0;
      resp_b_q  <= 1'b0;
      rdata_b_q <= '0;
    end else begin
      resp_b_q <= 1'b0;
      if (b_exec) begin
        resp_b_q <= 1'b1;
        if (!b_exec_wr) rdata_b_q <= mem_q[b_exec_idx];
      end
      case (b_state_q)
        S_IDLE: begin
          if (b_accept) begin
            b_idx_q   <= address_b[AW+1:2];
            b_wr_q    <= write;
            b_mask_q  <= wmask;
            b_wdata_q <= wdata;
            b_cnt_q   <= WAIT_INIT;
            b_state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (b_abort) begin
            b_state_q <= S_IDLE;
            b_cnt_q   <= '0;
          end else if (b_cnt_q == '0) begin
            b_state_q <= S_RESP;
          end else begin
            b_cnt_q <= b_cnt_q - 4'd1;
          end
        end
        S_RESP:  b_state_q <= S_IDLE;
        default: b_state_q <= S_IDLE;
      endcase
    end
  end

  // Array has no reset so preloaded contents survive; commits are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && b_exec && b_exec_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (b_exec_mask[i]) mem_q[b_exec_idx][8*i +: 8] <= b_exec_wdata[8*i +: 8];
      end
    end
  end

  assign resp_a  = resp_a_q;
  assign rdata_a = rdata_a_q;
  assign resp_b  = resp_b_q;
  assign rdata_b = rdata_b_q;

`ifdef DPMEM_PROTO_CHECK_EN
  logic proto_err_q;
  logic b_conflict;

  assign b_conflict = (b_state_q == S_IDLE) && read_b && write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if (b_conflict || a_abort || b_abort) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_a[31:AW+2], address_a[1:0],
                              address_b[31:AW+2], address_b[1:0]};

endmodule
